servo_bank_ctrl: RTL and testbench

//  Motion controller for a bank of servo channels. Accepts per-channel target positions over a

---
 rtl/servo_bank_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_servo_bank_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/servo_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servo_bank_ctrl
// Brief    : Frame-paced, rate-limited position ramp for a bank of servo channels.
//            Optional arrive_o pulses are enabled by defining SERVO_ARRIVE_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module servo_bank_ctrl #(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int N_CH       = 4,
    parameter int FRAME_MS   = 20,
    parameter int STEP       = 1,
    parameter int INIT_POS   = 128,
    localparam int CW        = $clog2(N_CH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CW-1:0]     cmd_ch_i,
    input  logic [N-1:0]      cmd_pos_i,
    output logic [N_CH*N-1:0] pos_o,
    output logic [N_CH-1:0]   en_o,
    output logic              frame_o,
    output logic              busy_o,
    output logic              err_o
`ifdef SERVO_ARRIVE_IRQ_EN
    ,
    output logic [N_CH-1:0]   arrive_o
`endif
);

    localparam int MS_CYC = 1_000_000 / CLK_PER_NS;
    localparam int MSW    = $clog2(MS_CYC + 1);
    localparam int FW     = $clog2(FRAME_MS + 1);

    localparam logic [N-1:0] STEP_N = N'(STEP);
    localparam logic [N-1:0] INIT_N = N'(INIT_POS);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] UPDATE = 1'b1;

    logic [MSW-1:0]  ms_cnt;
    logic [FW-1:0]   frame_cnt;
    logic            frame_q;
    logic [0:0]      state;
    logic [CW-1:0]   idx;
    logic [N-1:0]    cur [N_CH];
    logic [N-1:0]    tgt [N_CH];
    logic [N_CH-1:0] chan_en;
    logic            busy_q;
    logic            err_q;
    logic            any_diff;
    logic            ms_last;
    logic            frame_last;
    logic            cmd_fire;
    logic            ch_ok;
`ifdef SERVO_ARRIVE_IRQ_EN
    logic [N_CH-1:0] arrive_q;
`endif

    // Move c toward t by at most STEP; the clamp keeps it from overshooting.
    function automatic logic [N-1:0] ramp(input logic [N-1:0] c, input logic [N-1:0] t);
        if (c < t)
            return ((t - c) > STEP_N) ? (c + STEP_N) : t;
        else if (c > t)
            return ((c - t) > STEP_N) ? (c - STEP_N) : t;
        else
            return c;
    endfunction

    assign ms_last    = (ms_cnt == MSW'(MS_CYC - 1));
    assign frame_last = (frame_cnt == FW'(FRAME_MS - 1));
    assign frame_o    = frame_q & en_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || !en_i) begin
            ms_cnt    <= '0;
            frame_cnt <= '0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= ms_last && frame_last;
            if (ms_last) begin
                ms_cnt    <= '0;
                frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
            end else begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

    assign cmd_ready_o = (state == IDLE) && rstn_i;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign ch_ok       = (int'(cmd_ch_i) < N_CH);

    always_comb begin
        any_diff = 1'b0;
        for (int k = 0; k < N_CH; k++)
            if (cur[k] != tgt[k])
                any_diff = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            idx     <= '0;
            chan_en <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cur[k] <= INIT_N;
                tgt[k] <= INIT_N;
            end
`ifdef SERVO_ARRIVE_IRQ_EN
            arrive_q <= '0;
`endif
        end else begin
            busy_q <= any_diff;
`ifdef SERVO_ARRIVE_IRQ_EN
            arrive_q <= '0;
`endif
            // Commands only land in IDLE, so they never race the ramp writes.
            if (cmd_fire) begin
                if (ch_ok) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (cmd_ch_i == CW'(k)) begin
                            tgt[k]     <= cmd_pos_i;
                            chan_en[k] <= 1'b1;
                        end
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (!en_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_o) begin
                            state <= UPDATE;
                            idx   <= '0;
                        end
                    end
                    default: begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (idx == CW'(k)) begin
                                cur[k] <= ramp(cur[k], tgt[k]);
`ifdef SERVO_ARRIVE_IRQ_EN
                                arrive_q[k] <= (cur[k] != tgt[k]) &&
                                               (ramp(cur[k], tgt[k]) == tgt[k]);
`endif
                            end
                        end
                        if (idx == CW'(N_CH - 1))
                            state <= IDLE;
                        else
                            idx <= idx + 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_pos
        assign pos_o[k*N +: N] = cur[k];
    end

    assign en_o   = {N_CH{en_i}} & chan_en;
    assign busy_o = busy_q;
    assign err_o  = err_q;
`ifdef SERVO_ARRIVE_IRQ_EN
    assign arrive_o = arrive_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_servo_bank_ctrl.sv
`default_nettype none
// Directed bench for servo_bank_ctrl: 3 channels, STEP=4, a frame every 20 cycles.
module tb_servo_bank_ctrl;

    localparam int N    = 8;
    localparam int N_CH = 3;
    localparam int CW   = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CW-1:0]     cmd_ch;
    logic [N-1:0]      cmd_pos;
    logic [N_CH*N-1:0] pos;
    logic [N_CH-1:0]   en_out;
    logic              frame;
    logic              busy;
    logic              err;
`ifdef SERVO_ARRIVE_IRQ_EN
    logic [N_CH-1:0]   arrive;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int arrive_cnt1 = 0;

    servo_bank_ctrl #(
        .CLK_PER_NS(100000), .N(N), .N_CH(N_CH),
        .FRAME_MS(2), .STEP(4), .INIT_POS(128)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ch_i(cmd_ch), .cmd_pos_i(cmd_pos),
        .pos_o(pos), .en_o(en_out), .frame_o(frame),
        .busy_o(busy), .err_o(err)
`ifdef SERVO_ARRIVE_IRQ_EN
        , .arrive_o(arrive)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ch_pos(input int k);
        return pos[k*N +: N];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef SERVO_ARRIVE_IRQ_EN
        if (arrive[1]) arrive_cnt1++;
`endif
    endtask

    task automatic wait_frame();
        int i;
        for (i = 0; i < 50 && !frame; i++) tick();
        check("frame_timeout", {31'd0, frame}, 32'd1);
    endtask

    task automatic do_frame();
        wait_frame();
        repeat (4) tick();
    endtask

    task automatic send(input logic [CW-1:0] ch, input logic [N-1:0] p);
        cmd_valid = 1'b1; cmd_ch = ch; cmd_pos = p;
        check("send_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_pos = '0;
        tick(); tick();
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        for (int k = 0; k < N_CH; k++) check("rst_pos", ch_pos(k), 128);
        check("rst_en", en_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_frame", frame, 0);
        rstn = 1'b1;
        tick();
        check("ready_after_rst", cmd_ready, 1);

        // ch1 ramps 128 -> 140 in three frames of +4
        en = 1'b1;
        send(1, 140);
        check("en_ch1", en_out, 3'b010);
        tick();
        check("busy_set", busy, 1);
        do_frame();
        check("ch1_f1", ch_pos(1), 132);
        check("busy_mid", busy, 1);
        do_frame();
        check("ch1_f2", ch_pos(1), 136);
        do_frame();
        check("ch1_f3", ch_pos(1), 140);
        check("busy_clear", busy, 0);
        check("ch0_hold", ch_pos(0), 128);
        check("ch2_hold", ch_pos(2), 128);
`ifdef SERVO_ARRIVE_IRQ_EN
        check("arrive1_once", arrive_cnt1, 1);
`endif

        // clamp: 128 -> 126 in one frame, not 124
        send(2, 126);
        do_frame();
        check("ch2_clamp", ch_pos(2), 126);

        // command raised the cycle after frame_o waits out UPDATE
        wait_frame();
        tick();
        cmd_valid = 1'b1; cmd_ch = 0; cmd_pos = 200;
        check("upd_ready0", cmd_ready, 0);
        tick();
        check("upd_ready1", cmd_ready, 0);
        tick();
        check("upd_ready2", cmd_ready, 0);
        tick();
        check("idle_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("en_all", en_out, 3'b111);
        check("ch0_not_moved", ch_pos(0), 128);

        // out-of-range channel
        send(3, 50);
        check("err_set", err, 1);
        check("err_ch0", ch_pos(0), 128);
        check("err_ch1", ch_pos(1), 140);
        check("err_ch2", ch_pos(2), 126);
        check("err_en", en_out, 3'b111);

        // ch0 128 -> 200, then pause, resume, reset mid-UPDATE
        do_frame();
        check("ch0_f1", ch_pos(0), 132);
        do_frame();
        check("ch0_f2", ch_pos(0), 136);
        en = 1'b0;
        #1;
        check("en_off", en_out, 0);
        n = 0;
        repeat (30) begin
            tick();
            if (frame) n++;
        end
        check("no_frame_off", n, 0);
        check("ch0_frozen", ch_pos(0), 136);
        en = 1'b1;
        n = 0;
        while (n < 40 && !frame) begin
            tick();
            n++;
        end
        check("resume_frame_delay", n, 20);
        repeat (4) tick();
        check("ch0_resume", ch_pos(0), 140);
        check("err_sticky", err, 1);
        wait_frame();
        tick();
        rstn = 1'b0;
        tick();
        for (int k = 0; k < N_CH; k++) check("rst2_pos", ch_pos(k), 128);
        check("rst2_en", en_out, 0);
        check("rst2_err", err, 0);
        check("rst2_ready", cmd_ready, 0);
        rstn = 1'b1;
        tick();
        check("rst2_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
